// File: rtl/load_store_unit_pkg.sv
// Shared definitions for the load/store unit: FSM state type, RV32I funct3
// codes for loads/stores, default memory depth and the request legality check.
package load_store_unit_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD   = 2'd1,
        ST_WR   = 2'd2,
        ST_RESP = 2'd3
    } lsu_state_t;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    localparam int unsigned DEPTH_WORDS_DEFAULT = 256;

    // True when the request must be answered with resp_err and no memory access.
    function automatic logic access_error(
        input logic        we,
        input logic [2:0]  funct3,
        input logic [31:0] addr,
        input int unsigned depth_words
    );
        logic legal;
        logic misaligned;
        logic out_of_range;
        if (we) begin
            legal = (funct3 == F3_SB) || (funct3 == F3_SH) || (funct3 == F3_SW);
        end else begin
            legal = (funct3 == F3_LB) || (funct3 == F3_LH) || (funct3 == F3_LW) ||
                    (funct3 == F3_LBU) || (funct3 == F3_LHU);
        end
        // funct3[1:0] encodes access size for both loads and stores
        misaligned   = ((funct3[1:0] == 2'b01) && addr[0]) ||
                       ((funct3[1:0] == 2'b10) && (addr[1:0] != 2'b00));
        out_of_range = (addr >= (depth_words << 2));
        return !legal || misaligned || out_of_range;
    endfunction

endpackage

// File: rtl/load_store_unit_align.sv
// Lane steering for the load/store unit (combinational).
//   funct3      : RV32I load/store funct3
//   byte_off    : byte offset within the word (addr[1:0])
//   word_in     : word read from memory
//   store_data  : store operand (low byte/half used for SB/SH)
//   load_data   : selected lane, sign/zero-extended
//   merged_word : word_in with the addressed byte/half replaced (whole word for SW)
module lsu_align
    import load_store_unit_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  byte_off,
    input  logic [31:0] word_in,
    input  logic [31:0] store_data,
    output logic [31:0] load_data,
    output logic [31:0] merged_word
);

    logic [31:0] shifted;

    always_comb begin
        shifted = word_in >> {byte_off, 3'b000};
        unique case (funct3)
            F3_LB:   load_data = {{24{shifted[7]}}, shifted[7:0]};
            F3_LH:   load_data = {{16{shifted[15]}}, shifted[15:0]};
            F3_LW:   load_data = word_in;
            F3_LBU:  load_data = {24'h0, shifted[7:0]};
            F3_LHU:  load_data = {16'h0, shifted[15:0]};
            default: load_data = 32'h0;
        endcase
    end

    always_comb begin
        merged_word = word_in;
        case (funct3[1:0])
            2'b00:   merged_word[{byte_off, 3'b000} +: 8]        = store_data[7:0];
            2'b01:   merged_word[{byte_off[1], 4'b0000} +: 16]   = store_data[15:0];
            default: merged_word = store_data;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Byte-addressed load/store front end for a word-addressed data memory.
// Accepts one RV32I load/store, performs sub-word stores as read-modify-write,
// extends load data and flags misaligned, out-of-range or illegal requests.
//   clk, rst               : clock, asynchronous active-low reset
//   req_valid/req_ready    : request handshake (ready only in IDLE)
//   req_we/funct3/addr/wdata : request fields, latched on accept
//   resp_valid/rdata/err   : one-cycle response pulse
//   mem_addr/wdata/rd_en/wr_en, mem_rdata : word memory port (combinational read)
//
// state   | meaning
// IDLE    | waiting for a request
// RD      | memory read: load lane capture, or old word for SB/SH merge
// WR      | memory write strobe
// RESP    | response pulse, bubble before next accept
module load_store_unit
    import load_store_unit_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = DEPTH_WORDS_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_rd_en,
    output logic        mem_wr_en,
    input  logic [31:0] mem_rdata
);

    lsu_state_t  state;
    logic        we_q;
    logic [2:0]  funct3_q;
    logic [1:0]  off_q;
    logic [31:0] wdata_q;
    logic [31:0] load_data;
    logic [31:0] merged_word;

    lsu_align u_align (
        .funct3      (funct3_q),
        .byte_off    (off_q),
        .word_in     (mem_rdata),
        .store_data  (wdata_q),
        .load_data   (load_data),
        .merged_word (merged_word)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= ST_IDLE;
            req_ready  <= 1'b0;
            we_q       <= 1'b0;
            funct3_q   <= 3'b000;
            off_q      <= 2'b00;
            wdata_q    <= 32'h0;
            resp_valid <= 1'b0;
            resp_rdata <= 32'h0;
            resp_err   <= 1'b0;
            mem_addr   <= 32'h0;
            mem_wdata  <= 32'h0;
            mem_rd_en  <= 1'b0;
            mem_wr_en  <= 1'b0;
        end else begin
            resp_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    req_ready <= 1'b1;
                    if (req_valid && req_ready) begin
                        req_ready  <= 1'b0;
                        we_q       <= req_we;
                        funct3_q   <= req_funct3;
                        off_q      <= req_addr[1:0];
                        wdata_q    <= req_wdata;
                        resp_rdata <= 32'h0;
                        if (access_error(req_we, req_funct3, req_addr, DEPTH_WORDS)) begin
                            resp_err   <= 1'b1;
                            resp_valid <= 1'b1;
                            state      <= ST_RESP;
                        end else begin
                            resp_err <= 1'b0;
                            mem_addr <= {2'b00, req_addr[31:2]};
                            // Full-word stores need no old data, so they skip the read.
                            if (req_we && (req_funct3 == F3_SW)) begin
                                mem_wdata <= req_wdata;
                                mem_wr_en <= 1'b1;
                                state     <= ST_WR;
                            end else begin
                                mem_rd_en <= 1'b1;
                                state     <= ST_RD;
                            end
                        end
                    end
                end
                ST_RD: begin
                    mem_rd_en <= 1'b0;
                    if (we_q) begin
                        mem_wdata <= merged_word;
                        mem_wr_en <= 1'b1;
                        state     <= ST_WR;
                    end else begin
                        resp_rdata <= load_data;
                        resp_valid <= 1'b1;
                        state      <= ST_RESP;
                    end
                end
                ST_WR: begin
                    mem_wr_en  <= 1'b0;
                    resp_valid <= 1'b1;
                    state      <= ST_RESP;
                end
                ST_RESP: begin
                    resp_rdata <= 32'h0;
                    resp_err   <= 1'b0;
                    req_ready  <= 1'b1;
                    state      <= ST_IDLE;
                end
                default: begin
                    mem_rd_en <= 1'b0;
                    mem_wr_en <= 1'b0;
                    req_ready <= 1'b0;
                    state     <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
